hps_key_pio: RTL and testbench
==============================

# hps_key_pio

Avalon-MM slave input PIO for the HPS lightweight bridge, the read-side counterpart of the LED output PIO. It samples up to 32 asynchronous push-button/switch lines, synchronises and debounces each line, latches selected edges into a write-1-to-clear capture register and raises a maskable level interrupt to the HPS.

## Interface
- WIDTH, 4: number of input lines, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a synchronised input must differ from the debounced value before that value updates, ≥1 (1 ms at 50 MHz).
- EDGE_MODE, 1: 0 = rising, 1 = falling, 2 = any edge of the debounced value sets capture.
- RESET_LEVEL, all ones: reset value of synchroniser flops and debounced value (keys idle high).

- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous raw inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map, word addresses:
  - 0 DATA, RO: debounced value. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, RW: bits [WIDTH-1:0]; higher writedata bits dropped.
  - 3 EDGECAPTURE, R/W1C: writing 1 to bit i clears bit i; writing 0 leaves it unchanged.
- Write occurs when chipselect && !write_n. Reads have no side effects.
- Per bit i, a 2-flop synchroniser feeds sync[i].
- Per bit i, counter cnt[i] has width max(1, clog2(DEBOUNCE_CYCLES)).
  - sync[i] == deb[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches deb.
- Edge event on bit i means deb[i] updates this edge with a direction accepted by EDGE_MODE. On that same clock edge edgecapture[i] <= 1.
- Simultaneous edge event and W1C on the same bit: the set wins, and the bit stays 1.
- irq = |(edgecapture & irqmask), combinational from registers. No edge events are lost while masked: capture still sets and irq asserts as soon as the mask bit is set.
- Reset values:
  - sync flops and deb = RESET_LEVEL.
  - cnt = 0.
  - IRQMASK = 0, EDGECAPTURE = 0, irq = 0.
  - readdata follows address from those values.
- Reset asserted mid-count or mid-bounce discards all progress. No edge event is generated by reset or by the first cycles after it.

## Timing
- readdata is a combinational mux of registered state with zero wait states and read latency 0.
- Register writes take effect on the clock edge where the write is sampled and are visible on the next cycle.
- Input path: with in_port stable from before edge 1, sync[i] differs after edge 2 and deb[i] updates on edge DEBOUNCE_CYCLES+2. edgecapture[i] and irq, if masked in, are visible in the same cycle as the new DATA.
- Maximum input event rate is one debounced transition per DEBOUNCE_CYCLES cycles per bit. Bits are independent.
- Counters never wrap, because the terminal count always reloads 0.

## Test plan
Bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=1, RESET_LEVEL=4'hF.

1. Reset, then read addresses 0..3.
   - Expect 0xF, 0, 0, 0 and irq=0.
2. Hold in_port[0] low from before edge 1.
   - DATA reads 0xE from the cycle after edge 6, and EDGECAPTURE=0x1 in the same cycle.
   - With IRQMASK=0, irq stays 0.
   - Write IRQMASK=0x1: irq=1 on the next cycle.
3. Pulse in_port[1] low for 3 cycles, then high.
   - DATA stays 0xF and EDGECAPTURE stays 0.
   - Repeat with a 5-cycle pulse: bit 1 falls (capture 0x2), then rises with no capture.
4. With EDGECAPTURE=0x3 and IRQMASK=0x3, write 0x1 to address 3.
   - EDGECAPTURE reads 0x2 and irq stays 1.
   - Write 0x2: reads 0 and irq drops the next cycle.
5. Arrange a bit-2 falling event on the same edge as a W1C write of 0x4.
   - EDGECAPTURE bit 2 reads 1.
   - Write 0xFFFFFFFF to address 0: DATA is unchanged.
6. Assert reset for 1 cycle while in_port[3] has been low for 2 debounce cycles, keeping it low afterwards.
   - DATA reads 0xF immediately after reset.
   - DATA reads 0x7 at edge 6 counted from reset release, and EDGECAPTURE=0x8.

Source files
------------

// File: rtl/hps_key_pio.sv
// hps_key_pio: Avalon-MM input PIO for the HPS lightweight bridge.
// Synchronises, debounces and edge-captures push-button/switch lines.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   address[1:0]      - word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect        - slave select
//   write_n           - active-low write strobe
//   writedata[31:0]   - write data
//   readdata[31:0]    - combinational read data, zero-extended above WIDTH
//   in_port[WIDTH-1:0]- asynchronous raw inputs
//   irq               - level interrupt, |(edgecapture & irqmask)
module hps_key_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_nxt;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic             wr;

    assign wr = chipselect & ~write_n;

    // Counter restarts whenever the synchronised line agrees with the
    // debounced value; reaching the terminal count commits the new level.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == TERM) begin
                    deb_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_nxt & ~deb;
    assign fall = ~deb_nxt & deb;

    always_comb begin
        case (EDGE_MODE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
    end

    assign w1c = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= RESET_LEVEL;
            sync2   <= RESET_LEVEL;
            deb     <= RESET_LEVEL;
            irqmask <= '0;
            edgecap <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            deb   <= deb_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // A new edge event outranks a simultaneous clear.
            edgecap <= (edgecap & ~w1c) | ev;
            if (wr && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = 32'(deb);
            2'd2:    readdata = 32'(irqmask);
            2'd3:    readdata = 32'(edgecap);
            default: readdata = 32'd0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_hps_key_pio.sv
// tb_hps_key_pio: self-checking bench for hps_key_pio.
// Vector table, directed corner sequences and a randomised model check.
module tb_hps_key_pio;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int checks = 0;
    int failures = 0;

    hps_key_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(1),
        .RESET_LEVEL(4'hF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    // Behavioural model: raw samples reach the debouncer two edges late;
    // a bit flips once its last D samples all disagree with it.
    logic [W-1:0] m_deb;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap;
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_hist[$];

    task automatic model_reset();
        m_deb  = 4'hF;
        m_mask = '0;
        m_cap  = '0;
        m_pipe = {4'hF, 4'hF};
        m_hist = {};
    endtask

    task automatic model_edge(input logic rst, input logic [W-1:0] din,
                              input logic cs, input logic wn,
                              input logic [1:0] a, input logic [31:0] wd);
        logic [W-1:0] s;
        logic [W-1:0] nd;
        logic [W-1:0] clr;
        logic         all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(din);
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        nd = m_deb;
        for (int b = 0; b < W; b++) begin
            all_diff = (m_hist.size() == D);
            foreach (m_hist[k]) begin
                if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
            end
            if (all_diff) nd[b] = ~m_deb[b];
        end
        clr = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | (m_deb & ~nd);
        if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
        m_deb = nd;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, input string nm,
                      input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [W-1:0] cur;
    logic         rst_r;

    initial begin
        reset   = 1'b1;
        address = '0;
        in_port = 4'hF;
        idle();
        step();
        step();
        reset = 1'b0;

        // Register map after reset, IRQMASK width and write/ignore rules.
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFF5, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h5, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h5, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'hF,        32'h0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 32'hF,        32'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
        foreach (vecs[i]) begin
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            address    = vecs[i].addr;
            writedata  = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
            step();
        end
        idle();

        // Single falling key: commit on edge D+2, masked irq.
        in_port = 4'hE;
        do_reset();
        repeat (5) step();
        rd(0, "fall_pre", 32'hF);
        step();
        rd(0, "fall_data", 32'hE);
        rd(3, "fall_cap", 32'h1);
        chk_irq("fall_irq_masked", 1'b0);
        wr(2, 32'h1);
        chk_irq("fall_irq_unmask", 1'b1);

        // Short glitch never reaches DATA.
        in_port = 4'hF;
        do_reset();
        in_port = 4'hD;
        repeat (3) step();
        in_port = 4'hF;
        for (int k = 0; k < 8; k++) begin
            rd(0, "glitch_data", 32'hF);
            rd(3, "glitch_cap", 32'h0);
            step();
        end

        // Long pulse: fall is captured, release is not.
        in_port = 4'hD;
        repeat (5) step();
        in_port = 4'hF;
        rd(0, "pulse_pre", 32'hF);
        step();
        rd(0, "pulse_fall", 32'hD);
        rd(3, "pulse_cap", 32'h2);
        wr(3, 32'h2);
        rd(3, "pulse_clr", 32'h0);
        repeat (3) step();
        rd(0, "pulse_low", 32'hD);
        step();
        rd(0, "pulse_rise", 32'hF);
        rd(3, "pulse_rise_cap", 32'h0);

        // Partial W1C keeps irq, full clear drops it.
        in_port = 4'hF;
        do_reset();
        in_port = 4'hC;
        repeat (6) step();
        rd(3, "w1c_setup", 32'h3);
        wr(2, 32'h3);
        chk_irq("w1c_irq_on", 1'b1);
        wr(3, 32'h1);
        rd(3, "w1c_part", 32'h2);
        chk_irq("w1c_irq_kept", 1'b1);
        wr(3, 32'h2);
        rd(3, "w1c_full", 32'h0);
        chk_irq("w1c_irq_off", 1'b0);

        // Capture set wins over a clear on the same edge; DATA is RO.
        in_port = 4'hF;
        do_reset();
        in_port = 4'hB;
        repeat (5) step();
        wr(3, 32'h4);
        rd(3, "race_cap", 32'h4);
        rd(0, "race_data", 32'hB);
        wr(0, 32'hFFFFFFFF);
        rd(0, "data_ro", 32'hB);
        wr(3, 32'h4);
        rd(3, "race_clr", 32'h0);

        // Reset discards debounced state; key re-detected afterwards.
        in_port = 4'hF;
        do_reset();
        in_port = 4'h7;
        repeat (2 * D) step();
        rd(0, "rst_before", 32'h7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(0, "rst_data", 32'hF);
        rd(3, "rst_cap", 32'h0);
        chk_irq("rst_irq", 1'b0);
        repeat (5) step();
        rd(0, "rst_pre", 32'hF);
        step();
        rd(0, "rst_fall", 32'h7);
        rd(3, "rst_fall_cap", 32'h8);

        // Randomised traffic against the model.
        in_port = 4'hF;
        do_reset();
        model_reset();
        cur = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            rst_r = ($urandom_range(399) == 0);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(6) == 0) cur[b] = ~cur[b];
            end
            reset      = rst_r;
            in_port    = cur;
            chipselect = ($urandom_range(3) == 0);
            write_n    = 1'($urandom_range(1));
            address    = 2'($urandom_range(3));
            writedata  = $urandom;
            #1;
            chk("rand_rd", readdata, m_read(address));
            chk_irq("rand_irq", |(m_cap & m_mask));
            model_edge(rst_r, cur, chipselect, write_n, address, writedata);
            step();
        end
        reset = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
